// File: rtl/mips_mem_arbiter_pkg.sv
// Shared types and constants for the MIPS data-memory arbiter.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// Fetch, load/store and memory-side signal bundle for mips_mem_arbiter.
interface mips_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [1:0]        dm_size;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_done;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_err;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic [1:0]        mem_store_ctrl;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_read_data;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_size, dm_addr, dm_wdata, mem_read_data,
    output if_gnt, if_done, if_rdata, dm_gnt, dm_done, dm_rdata, dm_err,
           mem_address, mem_write_data, mem_store_ctrl, mem_read, mem_write
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_size, dm_addr, dm_wdata, mem_read_data,
    input  if_gnt, if_done, if_rdata, dm_gnt, dm_done, dm_rdata, dm_err,
           mem_address, mem_write_data, mem_store_ctrl, mem_read, mem_write
  );
endinterface

// File: rtl/mips_rr_arb2.sv
// Two-way picker: round-robin by default, fixed data-port priority when
// MIPS_MEM_ARB_DATA_PRIO_EN is defined.
module mips_rr_arb2
  import mips_mem_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_if,
  input  logic req_dm,
  input  logic upd,
  output logic valid_c,
  output logic pick_c
);

`ifdef MIPS_MEM_ARB_DATA_PRIO_EN
  logic unused_arb;
  assign unused_arb = ^{clk, rst_n, upd};

  always_comb begin
    valid_c = req_if | req_dm;
    pick_c  = req_dm ? PORT_DM : PORT_IF;
  end
`else
  logic last_q;

  // Most recent winner; reset to fetch so the data port wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   last_q <= PORT_IF;
    else if (upd) last_q <= pick_c;
  end

  always_comb begin
    valid_c = req_if | req_dm;
    if (req_if && req_dm) pick_c = (last_q == PORT_IF) ? PORT_DM : PORT_IF;
    else                  pick_c = req_dm ? PORT_DM : PORT_IF;
  end
`endif

endmodule

// File: rtl/mips_mem_arbiter.sv
// Arbiter/sequencer sharing the single-ported data memory between fetch and
// load/store ports. Priority mode selected by MIPS_MEM_ARB_DATA_PRIO_EN.
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input logic          clk,
  input logic          rst_n,
  mips_mem_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'(IDLE);
  localparam logic [1:0] S_ACCESS = 2'(ACCESS);
  localparam logic [1:0] S_RESP   = 2'(RESP);

  logic [1:0]        state_q, state_d;
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              if_gnt_q, if_gnt_d, dm_gnt_q, dm_gnt_d;
  logic              if_done_q, if_done_d, dm_done_q, dm_done_d;
  logic              dm_err_q, dm_err_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        ctrl_q, ctrl_d;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic              arb_valid_c, arb_pick_c, arb_upd_c;

  mips_rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_if  (bus.if_req),
    .req_dm  (bus.dm_req),
    .upd     (arb_upd_c),
    .valid_c (arb_valid_c),
    .pick_c  (arb_pick_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      port_q     <= PORT_IF;
      we_q       <= 1'b0;
      size_q     <= SZ_WORD;
      if_gnt_q   <= 1'b0;
      dm_gnt_q   <= 1'b0;
      if_done_q  <= 1'b0;
      dm_done_q  <= 1'b0;
      dm_err_q   <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ctrl_q     <= SZ_WORD;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      port_q     <= port_d;
      we_q       <= we_d;
      size_q     <= size_d;
      if_gnt_q   <= if_gnt_d;
      dm_gnt_q   <= dm_gnt_d;
      if_done_q  <= if_done_d;
      dm_done_q  <= dm_done_d;
      dm_err_q   <= dm_err_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ctrl_q     <= ctrl_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
    end
  end

  // Next state plus next registered outputs; pulses default low each cycle.
  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    we_d       = we_q;
    size_d     = size_q;
    if_gnt_d   = 1'b0;
    dm_gnt_d   = 1'b0;
    if_done_d  = 1'b0;
    dm_done_d  = 1'b0;
    dm_err_d   = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ctrl_d     = SZ_WORD;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    arb_upd_c  = 1'b0;

    case (state_q)
      S_IDLE, S_RESP: begin
        if (arb_valid_c) begin
          state_d   = S_ACCESS;
          arb_upd_c = 1'b1;
          port_d    = arb_pick_c;
          if (arb_pick_c == PORT_DM) begin
            dm_gnt_d = 1'b1;
            addr_d   = bus.dm_addr;
            wdata_d  = bus.dm_wdata;
            we_d     = bus.dm_we;
            size_d   = bus.dm_size;
            if (!bus.dm_we) begin
              rd_d = 1'b1;
            end else if (bus.dm_size != SZ_RSVD) begin
              wr_d   = 1'b1;
              ctrl_d = bus.dm_size;
            end
          end else begin
            if_gnt_d = 1'b1;
            addr_d   = bus.if_addr;
            we_d     = 1'b0;
            size_d   = SZ_WORD;
            rd_d     = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
        if (port_q == PORT_DM) begin
          dm_done_d = 1'b1;
          dm_err_d  = we_q && (size_q == SZ_RSVD);
          if (!we_q) dm_rdata_d = bus.mem_read_data;
        end else begin
          if_done_d  = 1'b1;
          if_rdata_d = bus.mem_read_data;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.if_gnt         = if_gnt_q;
  assign bus.if_done        = if_done_q;
  assign bus.if_rdata       = if_rdata_q;
  assign bus.dm_gnt         = dm_gnt_q;
  assign bus.dm_done        = dm_done_q;
  assign bus.dm_rdata       = dm_rdata_q;
  assign bus.dm_err         = dm_err_q;
  assign bus.mem_address    = addr_q;
  assign bus.mem_write_data = wdata_q;
  assign bus.mem_store_ctrl = ctrl_q;
  assign bus.mem_read       = rd_q;
  assign bus.mem_write      = wr_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench for mips_mem_arbiter: directed vector table, corner
// sequences and randomized two-port traffic against a transaction model.
module tb_mips_mem_arbiter;
  import mips_mem_pkg::*;

`ifdef MIPS_MEM_ARB_DATA_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_run  = 0;
  int   n_fail = 0;

  mips_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in for mips_memory: combinational read, negedge write.
  logic [31:0] mem [256];
  logic        pre_we;
  logic [7:0]  pre_a;
  logic [31:0] pre_d;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] sz);
    case (sz)
      SZ_WORD: return wd;
      SZ_HALF: return {old[31:16], wd[15:0]};
      SZ_BYTE: return {old[31:8], wd[7:0]};
      default: return old;
    endcase
  endfunction

  assign bus.mem_read_data = mem[bus.mem_address[7:0]];

  always @(negedge clk) begin
    if (pre_we) mem[pre_a] <= pre_d;
    else if (bus.mem_write)
      mem[bus.mem_address[7:0]] <= merge(mem[bus.mem_address[7:0]], bus.mem_write_data,
                                         bus.mem_store_ctrl);
  end

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    pre_a  = a;
    pre_d  = d;
    pre_we = 1'b1;
    @(negedge clk);
    #1;
    pre_we = 1'b0;
  endtask

  task automatic clear_req();
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
  endtask

  function automatic logic [136:0] all_out();
    return {bus.if_gnt, bus.if_done, bus.if_rdata, bus.dm_gnt, bus.dm_done, bus.dm_rdata,
            bus.dm_err, bus.mem_address, bus.mem_write_data, bus.mem_store_ctrl,
            bus.mem_read, bus.mem_write};
  endfunction

  typedef struct {
    logic        port;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic        wr;
    logic [1:0]  ctrl;
    logic [31:0] rdata;  // port's rdata after done (held value for stores)
    logic        err;
  } vec_t;

  vec_t vt [10];

  // Random-phase model state
  logic [31:0] ref_mem [16];
  logic [31:0] rv;
  logic        m_last, acc_prev, acc_now, win;
  logic        tx_port, tx_we;
  logic [1:0]  tx_sz;
  logic [31:0] tx_rdata, m_if_rd, m_dm_rd;
  logic        eg_if, eg_dm, ed_if, ed_dm, e_err;
  logic        r_ir, r_dr, r_dwe;
  logic [1:0]  r_dsz;
  logic [31:0] r_ia, r_da, r_dw;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; pre_we = 1'b0; pre_a = '0; pre_d = '0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_size = SZ_WORD;
    bus.dm_addr = '0; bus.dm_wdata = '0;

    vt[0] = '{PORT_IF, 1'b0, SZ_WORD, 32'd5, 32'd0,          1'b1, 1'b0, SZ_WORD, 32'hDEADBEEF, 1'b0};
    vt[1] = '{PORT_DM, 1'b1, SZ_BYTE, 32'd3, 32'h12345678,   1'b0, 1'b1, SZ_BYTE, 32'h00000000, 1'b0};
    vt[2] = '{PORT_DM, 1'b0, SZ_WORD, 32'd3, 32'd0,          1'b1, 1'b0, SZ_WORD, 32'hCAFEF078, 1'b0};
    vt[3] = '{PORT_DM, 1'b1, SZ_HALF, 32'd7, 32'hAAAABBBB,   1'b0, 1'b1, SZ_HALF, 32'hCAFEF078, 1'b0};
    vt[4] = '{PORT_DM, 1'b0, SZ_WORD, 32'd7, 32'd0,          1'b1, 1'b0, SZ_WORD, 32'h1122BBBB, 1'b0};
    vt[5] = '{PORT_DM, 1'b1, SZ_WORD, 32'd9, 32'h0BADF00D,   1'b0, 1'b1, SZ_WORD, 32'h1122BBBB, 1'b0};
    vt[6] = '{PORT_IF, 1'b0, SZ_WORD, 32'd9, 32'd0,          1'b1, 1'b0, SZ_WORD, 32'h0BADF00D, 1'b0};
    vt[7] = '{PORT_DM, 1'b1, SZ_RSVD, 32'd5, 32'hFFFFFFFF,   1'b0, 1'b0, SZ_WORD, 32'h1122BBBB, 1'b1};
    vt[8] = '{PORT_DM, 1'b0, SZ_WORD, 32'd5, 32'd0,          1'b1, 1'b0, SZ_WORD, 32'hDEADBEEF, 1'b0};
    vt[9] = '{PORT_DM, 1'b0, SZ_WORD, 32'd0, 32'd0,          1'b1, 1'b0, SZ_WORD, 32'h00000000, 1'b0};

    for (int a = 0; a < 32; a++) poke(8'(a), 32'h0);
    poke(8'd3, 32'hCAFEF00D);
    poke(8'd5, 32'hDEADBEEF);
    poke(8'd7, 32'h11223344);
    poke(8'd9, 32'h55667788);
    tick();
    chk("reset_outputs", 160'(all_out()), 160'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_outputs", 160'(all_out()), 160'd0);

    // Directed single-port transactions
    for (int i = 0; i < 10; i++) begin
      if (vt[i].port == PORT_DM) begin
        bus.dm_req = 1'b1; bus.dm_we = vt[i].we; bus.dm_size = vt[i].size;
        bus.dm_addr = vt[i].addr; bus.dm_wdata = vt[i].wdata;
      end else begin
        bus.if_req = 1'b1; bus.if_addr = vt[i].addr;
      end
      tick();
      chk($sformatf("v%0d_gnt", i), {bus.if_gnt, bus.dm_gnt},
          (vt[i].port == PORT_DM) ? 2'b01 : 2'b10);
      chk($sformatf("v%0d_ctl", i), {bus.mem_read, bus.mem_write, bus.mem_store_ctrl},
          {vt[i].rd, vt[i].wr, vt[i].ctrl});
      chk($sformatf("v%0d_addr", i), bus.mem_address, vt[i].addr);
      if (vt[i].we) chk($sformatf("v%0d_wdata", i), bus.mem_write_data, vt[i].wdata);
      clear_req();
      tick();
      chk($sformatf("v%0d_done", i), {bus.if_done, bus.dm_done, bus.if_gnt, bus.dm_gnt},
          (vt[i].port == PORT_DM) ? 4'b0100 : 4'b1000);
      chk($sformatf("v%0d_rdata", i),
          (vt[i].port == PORT_DM) ? bus.dm_rdata : bus.if_rdata, vt[i].rdata);
      chk($sformatf("v%0d_err", i), bus.dm_err, vt[i].err);
      chk($sformatf("v%0d_ctl_off", i), {bus.mem_read, bus.mem_write, bus.mem_store_ctrl}, 4'd0);
      tick();
    end

    // Contention from reset
    rst_n = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'd5;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_size = SZ_WORD; bus.dm_addr = 32'd9;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      logic [1:0] eg, ed;
      tick();
      eg = 2'b00; ed = 2'b00;
      if (k % 2 == 0) eg = (PRIO || (k % 4 == 0)) ? 2'b01 : 2'b10;
      else            ed = (PRIO || (k % 4 == 1)) ? 2'b01 : 2'b10;
      chk($sformatf("cont%0d_gnt", k), {bus.if_gnt, bus.dm_gnt}, eg);
      chk($sformatf("cont%0d_done", k), {bus.if_done, bus.dm_done}, ed);
    end
    clear_req();
    tick(); tick();

    // Reset during a load's ACCESS cycle
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'd5;
    tick();
    chk("rst_mid_gnt", {bus.dm_gnt, bus.mem_read}, 2'b11);
    clear_req();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", 160'(all_out()), 160'd0);
    tick();
    chk("rst_mid_no_done", {bus.dm_done, bus.if_done}, 2'b00);
    bus.if_req = 1'b1; bus.dm_req = 1'b1;
    rst_n = 1'b1;
    tick();
    chk("rst_first_contended", {bus.if_gnt, bus.dm_gnt}, 2'b01);
    clear_req();
    tick(); tick();

    // Store then load of the same word, back-to-back
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_size = SZ_WORD;
    bus.dm_addr = 32'd20; bus.dm_wdata = 32'h600DCAFE;
    tick();
    chk("sl_store_gnt", {bus.dm_gnt, bus.mem_write, bus.mem_store_ctrl}, 4'b1100);
    bus.dm_we = 1'b0; bus.dm_wdata = 32'h0;
    tick();
    chk("sl_store_done", {bus.dm_done, bus.dm_err, bus.mem_write}, 3'b100);
    tick();
    chk("sl_load_gnt", {bus.dm_gnt, bus.mem_read, bus.mem_address}, {2'b11, 32'd20});
    clear_req();
    tick();
    chk("sl_load_done", {bus.dm_done, bus.dm_rdata}, {1'b1, 32'h600DCAFE});
    tick();

    // Randomized two-port traffic against a transaction-level model
    rst_n = 1'b0;
    clear_req();
    for (int a = 0; a < 16; a++) begin
      rv = $urandom;
      poke(8'(a), rv);
      ref_mem[a] = rv;
    end
    tick();
    rst_n = 1'b1;
    m_last = PORT_IF; acc_prev = 1'b0; m_if_rd = '0; m_dm_rd = '0;
    tx_port = PORT_IF; tx_we = 1'b0; tx_sz = SZ_WORD; tx_rdata = '0;
    r_ir = 1'b0; r_dr = 1'b0; r_dwe = 1'b0; r_dsz = SZ_WORD;
    r_ia = '0; r_da = '0; r_dw = '0;
    for (int c = 0; c < 600; c++) begin
      tick();
      eg_if = 1'b0; eg_dm = 1'b0; ed_if = 1'b0; ed_dm = 1'b0; e_err = 1'b0;
      if (acc_prev) begin
        if (tx_port == PORT_DM) begin
          ed_dm = 1'b1;
          e_err = tx_we && (tx_sz == SZ_RSVD);
          if (!tx_we) m_dm_rd = tx_rdata;
        end else begin
          ed_if   = 1'b1;
          m_if_rd = tx_rdata;
        end
      end
      acc_now = 1'b0;
      if (!acc_prev && (r_ir || r_dr)) begin
        if (r_ir && r_dr) win = (PRIO || m_last == PORT_IF) ? PORT_DM : PORT_IF;
        else              win = r_dr ? PORT_DM : PORT_IF;
        m_last  = win;
        acc_now = 1'b1;
        tx_port = win;
        if (win == PORT_DM) begin
          eg_dm    = 1'b1;
          tx_we    = r_dwe;
          tx_sz    = r_dsz;
          tx_rdata = ref_mem[r_da[3:0]];
          if (r_dwe) ref_mem[r_da[3:0]] = merge(ref_mem[r_da[3:0]], r_dw, r_dsz);
        end else begin
          eg_if    = 1'b1;
          tx_we    = 1'b0;
          tx_sz    = SZ_WORD;
          tx_rdata = ref_mem[r_ia[3:0]];
        end
      end
      acc_prev = acc_now;

      chk($sformatf("rnd%0d_hs", c), {bus.if_gnt, bus.dm_gnt, bus.if_done, bus.dm_done},
          {eg_if, eg_dm, ed_if, ed_dm});
      chk($sformatf("rnd%0d_if_rdata", c), bus.if_rdata, m_if_rd);
      chk($sformatf("rnd%0d_dm_rdata", c), bus.dm_rdata, m_dm_rd);
      chk($sformatf("rnd%0d_err", c), bus.dm_err, e_err);

      if (eg_if) r_ir = 1'b0;
      if (eg_dm) r_dr = 1'b0;
      if (!r_ir && $urandom_range(0, 2) == 0) begin
        r_ir = 1'b1;
        r_ia = 32'($urandom_range(0, 15));
      end
      if (!r_dr && $urandom_range(0, 2) == 0) begin
        r_dr  = 1'b1;
        r_dwe = 1'($urandom_range(0, 1));
        r_dsz = 2'($urandom_range(0, 3));
        r_da  = 32'($urandom_range(0, 15));
        r_dw  = $urandom;
      end
      bus.if_req = r_ir; bus.if_addr = r_ia;
      bus.dm_req = r_dr; bus.dm_we = r_dwe; bus.dm_size = r_dsz;
      bus.dm_addr = r_da; bus.dm_wdata = r_dw;
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_mem_arbiter.md
# mips_mem_arbiter

Two-port arbiter and sequencer for the single-ported MIPS data memory. It shares the memory between the instruction-fetch port (read-only) and the load/store port (read, or word/half/byte write), and sequences each access as a fixed three-state transaction. It registers all memory-side controls and returns read data with a one-cycle done pulse. It sits between the pipeline's fetch/MEM stages and `mips_memory`.

## Interface
- `ADDR_W`, 32, width of the word address passed to memory
- `DATA_W`, 32, data width
- `clk`  in  1  system clock; all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `if_req`  in  1  fetch port request
- `if_addr`  in  ADDR_W  fetch word address
- `if_gnt`  out  1  one-cycle pulse: fetch request accepted, payload latched
- `if_done`  out  1  one-cycle pulse: `if_rdata` valid
- `if_rdata`  out  DATA_W  fetched word, held until next fetch done
- `dm_req`  in  1  load/store port request
- `dm_we`  in  1  1 = store, 0 = load
- `dm_size`  in  2  store size: 00 word, 01 half [15:0], 10 byte [7:0], 11 reserved
- `dm_addr`  in  ADDR_W  data word address
- `dm_wdata`  in  DATA_W  store data
- `dm_gnt`  out  1  one-cycle pulse: data request accepted
- `dm_done`  out  1  one-cycle pulse: access complete, `dm_rdata` valid for loads
- `dm_rdata`  out  DATA_W  load data, held until next data done
- `dm_err`  out  1  valid with `dm_done`: store with `dm_size`=11 was suppressed
- `mem_address`  out  ADDR_W  memory address
- `mem_write_data`  out  DATA_W  memory write data
- `mem_store_ctrl`  out  2  memory store size control
- `mem_read`  out  1  memory read enable
- `mem_write`  out  1  memory write enable
- `mem_read_data`  in  DATA_W  memory combinational read data

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state: IDLE.
- IDLE or RESP with any request pending: arbitrate, latch the winner's payload, pulse its `gnt`, go to ACCESS. With no request pending: go to or stay in IDLE.
- Arbitration is round-robin over two ports. The `last` bit records the most recent winner. When both ports request, the port that did not win last is chosen. Reset value of `last` is fetch, so the data port wins first.
- ACCESS: memory controls are driven from registers.
  - Load or fetch: `mem_read`=1.
  - Store with size 00/01/10: `mem_write`=1 and `mem_store_ctrl`=size. Memory commits the write on the falling edge inside ACCESS.
  - Store with size 11: `mem_write` stays 0 and `dm_err` is set.
- At the end of ACCESS, `mem_read_data` is captured into the winner's rdata register (loads and fetches only), and the FSM goes to RESP.
- RESP: winner's `done` pulses and arbitration runs again, per the IDLE rule.
- Outside ACCESS, `mem_read`, `mem_write` and `mem_store_ctrl` are 0. `mem_address` and `mem_write_data` hold their last values.
- Requesters hold `req` and payload stable until `gnt`. A requester may deassert `req` in the cycle after `gnt` or later. Payload changes after `gnt` are ignored.
- Reset, including mid-transaction:
  - FSM returns to IDLE and `last` to fetch.
  - All outputs reset to 0, including rdata registers and `dm_err`.
  - Any in-flight access is dropped with no `done`. A write already committed on the falling edge is not undone.

## Timing
- Latency: `gnt` is visible in the cycle after `req` is sampled high in IDLE. ACCESS is that same cycle. `done` follows one cycle later.
- Back-to-back throughput: one access every 2 cycles (RESP overlaps the next grant). Two contending requesters alternate.
- Both `gnt` and both `done` are never high in the same cycle.
- `dm_err` is 0 whenever `dm_done` is 0.

## Configuration
- `MIPS_MEM_ARB_DATA_PRIO_EN`
  - Defined: fixed priority. The data port always wins when both request, and `last` is unused.
  - Undefined: round-robin as described above.

## Structure
- Package `mips_mem_pkg` holds:
  - the state enum (IDLE/ACCESS/RESP)
  - size constants SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10, SZ_RSVD=2'b11
  - port index constants PORT_IF=0, PORT_DM=1
- Sub-module `mips_rr_arb2`: a 2-way round-robin/priority picker containing the `last` bit and the macro switch. The FSM and datapath stay in the top module.

## Test plan
- Single fetch: `if_req`=1, `if_addr`=5, memory word 5 = 0xDEADBEEF -> `if_gnt` at cycle 1, `mem_read`=1 at cycle 1 only, `if_done`=1 with `if_rdata`=0xDEADBEEF at cycle 2.
- Byte store: `dm_we`=1, `dm_size`=10, `dm_addr`=3, `dm_wdata`=0x12345678 -> `mem_write`=1 and `mem_store_ctrl`=10 for exactly one cycle; a later load of address 3 returns the original upper 24 bits with low byte 0x78.
- Contention: both ports request continuously from reset -> grant order DM, IF, DM, IF, with a `done` every 2 cycles and never two `gnt` in one cycle. With the macro defined, grants go to DM only.
- Reserved size: store with `dm_size`=11 -> `mem_write` never asserted, `dm_done`=1 with `dm_err`=1, memory unchanged.
- Reset mid-operation: assert `rst_n`=0 during ACCESS of a load -> all outputs 0 immediately, no `dm_done`; after release, the first contended grant goes to DM.
- Load after store to the same address, issued back-to-back -> load returns the newly written word, 2 cycles after the store's `done`.
